// File: rtl/pulpemu_pkg.sv
// Shared types and helpers for the PULP SPI/AXI route switch.
package pulpemu_pkg;

    typedef enum logic {
        ROUTE_ZYNQ = 1'b0,
        ROUTE_FMC  = 1'b1
    } route_e;

    typedef enum logic [1:0] {
        ST_STEADY    = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_DRAIN     = 2'd2
    } switch_state_e;

    // Widest vector byte_swap can handle; callers zero-extend in and truncate out.
    localparam int unsigned BSWAP_MAX_W = 1024;

    function automatic logic [BSWAP_MAX_W-1:0] byte_swap(
        input logic [BSWAP_MAX_W-1:0] v,
        input int unsigned            nbytes
    );
        logic [BSWAP_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BSWAP_MAX_W / 8; i++) begin
            if (i < nbytes) r[8*i +: 8] = v[8*(nbytes-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pulpemu_outstanding_cnt.sv
// Up/down counter of in-flight AXI transactions with saturation guards.
module pulpemu_outstanding_cnt
    import pulpemu_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          inc_ok, dec_ok;

    assign full_o  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign empty_o = (cnt_q == '0);
    assign inc_ok  = inc_i & ~full_o;
    assign dec_ok  = dec_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_ok && !dec_ok)      cnt_d = cnt_q + CW'(1);
        else if (dec_ok && !inc_ok) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pulpemu_spi_route_switch.sv
// Glitch-free router of PULP quad-SPI between the on-chip AXI bridge and the FMC pads,
// with AXI channel gating and optional byte swapping on the bridge route.
module pulpemu_spi_route_switch
    import pulpemu_pkg::*;
#(
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned IDLE_CYCLES     = 16,
    parameter int unsigned RESET_ROUTE     = 0
) (
    input  logic                      zynq_clk,
    input  logic                      zynq_rst_n,
    input  logic                      route_req_i,
    input  logic                      swap_en_i,
    output logic                      route_o,
    output logic                      busy_o,
    // PULP SPI master pins
    input  logic                      pulp_spi_clk_i,
    input  logic                      pulp_spi_csn_i,
    input  logic [1:0]                pulp_spi_mode_i,
    input  logic [NUM_LANES-1:0]      pulp_spi_sdo_i,
    output logic [NUM_LANES-1:0]      pulp_spi_sdi_o,
    // bridge SPI side
    output logic                      br_spi_clk_o,
    output logic                      br_spi_csn_o,
    output logic [NUM_LANES-1:0]      br_spi_sdi_o,
    input  logic [NUM_LANES-1:0]      br_spi_sdo_i,
    // pad SPI side
    output logic                      pad_spi_clk_o,
    output logic                      pad_spi_csn_o,
    output logic [1:0]                pad_spi_mode_o,
    output logic [NUM_LANES-1:0]      pad_spi_sdo_o,
    input  logic [NUM_LANES-1:0]      pad_spi_sdi_i,
    // AW
    input  logic                      br_aw_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] br_aw_addr_i,
    output logic                      br_aw_ready_o,
    output logic                      zynq_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] zynq_aw_addr_o,
    input  logic                      zynq_aw_ready_i,
    // AR
    input  logic                      br_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] br_ar_addr_i,
    output logic                      br_ar_ready_o,
    output logic                      zynq_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] zynq_ar_addr_o,
    input  logic                      zynq_ar_ready_i,
    // W
    input  logic                      br_w_valid_i,
    input  logic                      br_w_last_i,
    input  logic [AXI_DATA_WIDTH-1:0] br_w_data_i,
    output logic                      br_w_ready_o,
    output logic                      zynq_w_valid_o,
    output logic                      zynq_w_last_o,
    output logic [AXI_DATA_WIDTH-1:0] zynq_w_data_o,
    input  logic                      zynq_w_ready_i,
    // R
    input  logic                      zynq_r_valid_i,
    input  logic                      zynq_r_last_i,
    input  logic [AXI_DATA_WIDTH-1:0] zynq_r_data_i,
    output logic                      zynq_r_ready_o,
    output logic                      br_r_valid_o,
    output logic                      br_r_last_o,
    output logic [AXI_DATA_WIDTH-1:0] br_r_data_o,
    input  logic                      br_r_ready_i,
    // B
    input  logic                      zynq_b_valid_i,
    output logic                      zynq_b_ready_o,
    output logic                      br_b_valid_o,
    input  logic                      br_b_ready_i
);

    localparam int unsigned IDLE_W  = $clog2(IDLE_CYCLES + 1);
    localparam route_e      RST_RTE = (RESET_ROUTE != 0) ? ROUTE_FMC : ROUTE_ZYNQ;

    logic             csn_meta_q, csn_s_q;
    switch_state_e    state_q;
    route_e           route_q, req;
    logic             busy_q, swap_q, swap_init_q;
    logic [IDLE_W-1:0] idle_cnt_q;

    logic drain, axi_on, aw_en, ar_en;
    logic wr_full, wr_empty, rd_full, rd_empty;
    logic aw_hs, ar_hs, b_hs, r_last_hs;

    assign req     = route_e'(route_req_i);
    assign route_o = route_q;
    assign busy_o  = busy_q;

    always_ff @(posedge zynq_clk or negedge zynq_rst_n) begin
        if (!zynq_rst_n) begin
            csn_meta_q <= 1'b1;
            csn_s_q    <= 1'b1;
        end else begin
            csn_meta_q <= pulp_spi_csn_i;
            csn_s_q    <= csn_meta_q;
        end
    end

    // Route switch FSM; a revert of route_req_i at any point abandons the switch.
    always_ff @(posedge zynq_clk or negedge zynq_rst_n) begin
        if (!zynq_rst_n) begin
            state_q     <= ST_STEADY;
            route_q     <= RST_RTE;
            busy_q      <= 1'b0;
            idle_cnt_q  <= '0;
            swap_q      <= 1'b0;
            swap_init_q <= 1'b0;
        end else begin
            if (!swap_init_q) begin
                swap_init_q <= 1'b1;
                swap_q      <= swap_en_i;
            end
            unique case (state_q)
                ST_STEADY: begin
                    if (req != route_q) begin
                        state_q    <= ST_WAIT_IDLE;
                        busy_q     <= 1'b1;
                        idle_cnt_q <= '0;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (req == route_q) begin
                        state_q <= ST_STEADY;
                        busy_q  <= 1'b0;
                    end else if (csn_s_q) begin
                        if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) state_q <= ST_DRAIN;
                        else idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (req == route_q) begin
                        state_q <= ST_STEADY;
                        busy_q  <= 1'b0;
                    end else if (wr_empty && rd_empty) begin
                        route_q <= req;
                        swap_q  <= swap_en_i;
                        state_q <= ST_STEADY;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_STEADY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign drain  = (state_q == ST_DRAIN);
    assign axi_on = (route_q == ROUTE_ZYNQ);
    assign aw_en  = axi_on & ~drain & ~wr_full;
    assign ar_en  = axi_on & ~drain & ~rd_full;

    always_comb begin
        pulp_spi_sdi_o = '0;
        br_spi_clk_o   = 1'b0;
        br_spi_csn_o   = 1'b1;
        br_spi_sdi_o   = '0;
        pad_spi_clk_o  = 1'b0;
        pad_spi_csn_o  = 1'b1;
        pad_spi_mode_o = 2'b00;
        pad_spi_sdo_o  = '0;
        if (!drain) begin
            if (route_q == ROUTE_ZYNQ) begin
                br_spi_clk_o   = pulp_spi_clk_i;
                br_spi_csn_o   = pulp_spi_csn_i;
                br_spi_sdi_o   = pulp_spi_sdo_i;
                pulp_spi_sdi_o = br_spi_sdo_i;
            end else begin
                pad_spi_clk_o  = pulp_spi_clk_i;
                pad_spi_csn_o  = pulp_spi_csn_i;
                pad_spi_mode_o = pulp_spi_mode_i;
                pad_spi_sdo_o  = pulp_spi_sdo_i;
                pulp_spi_sdi_o = pad_spi_sdi_i;
            end
        end
    end

    assign zynq_aw_valid_o = br_aw_valid_i & aw_en;
    assign br_aw_ready_o   = zynq_aw_ready_i & aw_en;
    assign zynq_aw_addr_o  = swap_q
        ? AXI_ADDR_WIDTH'(byte_swap(BSWAP_MAX_W'(br_aw_addr_i), AXI_ADDR_WIDTH / 8))
        : br_aw_addr_i;

    assign zynq_ar_valid_o = br_ar_valid_i & ar_en;
    assign br_ar_ready_o   = zynq_ar_ready_i & ar_en;
    assign zynq_ar_addr_o  = swap_q
        ? AXI_ADDR_WIDTH'(byte_swap(BSWAP_MAX_W'(br_ar_addr_i), AXI_ADDR_WIDTH / 8))
        : br_ar_addr_i;

    // W/R/B stay open during DRAIN so in-flight bursts can complete.
    assign zynq_w_valid_o = br_w_valid_i & axi_on;
    assign zynq_w_last_o  = br_w_last_i;
    assign br_w_ready_o   = zynq_w_ready_i & axi_on;
    assign zynq_w_data_o  = swap_q
        ? AXI_DATA_WIDTH'(byte_swap(BSWAP_MAX_W'(br_w_data_i), AXI_DATA_WIDTH / 8))
        : br_w_data_i;

    assign br_r_valid_o   = zynq_r_valid_i & axi_on;
    assign br_r_last_o    = zynq_r_last_i;
    assign zynq_r_ready_o = br_r_ready_i & axi_on;
    assign br_r_data_o    = swap_q
        ? AXI_DATA_WIDTH'(byte_swap(BSWAP_MAX_W'(zynq_r_data_i), AXI_DATA_WIDTH / 8))
        : zynq_r_data_i;

    assign br_b_valid_o   = zynq_b_valid_i & axi_on;
    assign zynq_b_ready_o = br_b_ready_i & axi_on;

    assign aw_hs     = zynq_aw_valid_o & zynq_aw_ready_i;
    assign ar_hs     = zynq_ar_valid_o & zynq_ar_ready_i;
    assign b_hs      = zynq_b_valid_i & zynq_b_ready_o;
    assign r_last_hs = zynq_r_valid_i & zynq_r_ready_o & zynq_r_last_i;

    pulpemu_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_cnt (
        .clk_i   (zynq_clk),
        .rst_ni  (zynq_rst_n),
        .inc_i   (aw_hs),
        .dec_i   (b_hs),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    pulpemu_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_cnt (
        .clk_i   (zynq_clk),
        .rst_ni  (zynq_rst_n),
        .inc_i   (ar_hs),
        .dec_i   (r_last_hs),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

endmodule

// File: tb/tb_pulpemu_spi_route_switch.sv
// Bench for the SPI route switch: directed scenarios plus random traffic against a reference model.
module tb_pulpemu_spi_route_switch;
  localparam int NL = 4, AW = 32, DW = 32, MAXO = 8, IDLE = 16;

  logic zynq_clk = 1'b0;
  logic zynq_rst_n = 1'b0;
  always #5 zynq_clk = ~zynq_clk;

  logic route_req_i, swap_en_i, route_o, busy_o;
  logic pulp_spi_clk_i, pulp_spi_csn_i;
  logic [1:0] pulp_spi_mode_i, pad_spi_mode_o;
  logic [NL-1:0] pulp_spi_sdo_i, pulp_spi_sdi_o, br_spi_sdi_o, br_spi_sdo_i, pad_spi_sdo_o, pad_spi_sdi_i;
  logic br_spi_clk_o, br_spi_csn_o, pad_spi_clk_o, pad_spi_csn_o;
  logic br_aw_valid_i, br_aw_ready_o, zynq_aw_valid_o, zynq_aw_ready_i;
  logic br_ar_valid_i, br_ar_ready_o, zynq_ar_valid_o, zynq_ar_ready_i;
  logic [AW-1:0] br_aw_addr_i, zynq_aw_addr_o, br_ar_addr_i, zynq_ar_addr_o;
  logic br_w_valid_i, br_w_last_i, br_w_ready_o, zynq_w_valid_o, zynq_w_last_o, zynq_w_ready_i;
  logic zynq_r_valid_i, zynq_r_last_i, zynq_r_ready_o, br_r_valid_o, br_r_last_o, br_r_ready_i;
  logic [DW-1:0] br_w_data_i, zynq_w_data_o, zynq_r_data_i, br_r_data_o;
  logic zynq_b_valid_i, zynq_b_ready_o, br_b_valid_o, br_b_ready_i;

  pulpemu_spi_route_switch #(
    .NUM_LANES(NL), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO), .IDLE_CYCLES(IDLE), .RESET_ROUTE(0)
  ) dut (
    .zynq_clk(zynq_clk), .zynq_rst_n(zynq_rst_n),
    .route_req_i(route_req_i), .swap_en_i(swap_en_i), .route_o(route_o), .busy_o(busy_o),
    .pulp_spi_clk_i(pulp_spi_clk_i), .pulp_spi_csn_i(pulp_spi_csn_i), .pulp_spi_mode_i(pulp_spi_mode_i),
    .pulp_spi_sdo_i(pulp_spi_sdo_i), .pulp_spi_sdi_o(pulp_spi_sdi_o),
    .br_spi_clk_o(br_spi_clk_o), .br_spi_csn_o(br_spi_csn_o), .br_spi_sdi_o(br_spi_sdi_o), .br_spi_sdo_i(br_spi_sdo_i),
    .pad_spi_clk_o(pad_spi_clk_o), .pad_spi_csn_o(pad_spi_csn_o), .pad_spi_mode_o(pad_spi_mode_o),
    .pad_spi_sdo_o(pad_spi_sdo_o), .pad_spi_sdi_i(pad_spi_sdi_i),
    .br_aw_valid_i(br_aw_valid_i), .br_aw_addr_i(br_aw_addr_i), .br_aw_ready_o(br_aw_ready_o),
    .zynq_aw_valid_o(zynq_aw_valid_o), .zynq_aw_addr_o(zynq_aw_addr_o), .zynq_aw_ready_i(zynq_aw_ready_i),
    .br_ar_valid_i(br_ar_valid_i), .br_ar_addr_i(br_ar_addr_i), .br_ar_ready_o(br_ar_ready_o),
    .zynq_ar_valid_o(zynq_ar_valid_o), .zynq_ar_addr_o(zynq_ar_addr_o), .zynq_ar_ready_i(zynq_ar_ready_i),
    .br_w_valid_i(br_w_valid_i), .br_w_last_i(br_w_last_i), .br_w_data_i(br_w_data_i), .br_w_ready_o(br_w_ready_o),
    .zynq_w_valid_o(zynq_w_valid_o), .zynq_w_last_o(zynq_w_last_o), .zynq_w_data_o(zynq_w_data_o),
    .zynq_w_ready_i(zynq_w_ready_i),
    .zynq_r_valid_i(zynq_r_valid_i), .zynq_r_last_i(zynq_r_last_i), .zynq_r_data_i(zynq_r_data_i),
    .zynq_r_ready_o(zynq_r_ready_o), .br_r_valid_o(br_r_valid_o), .br_r_last_o(br_r_last_o),
    .br_r_data_o(br_r_data_o), .br_r_ready_i(br_r_ready_i),
    .zynq_b_valid_i(zynq_b_valid_i), .zynq_b_ready_o(zynq_b_ready_o),
    .br_b_valid_o(br_b_valid_o), .br_b_ready_i(br_b_ready_i)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: route, phase (0 steady, 1 waiting for idle, 2 draining),
  // consecutive idle samples, outstanding write/read counts, swap, csn sync history
  bit m_route, m_swap, m_started;
  int m_phase, m_run, m_wr, m_rd;
  bit m_sync [2];

  function automatic logic [127:0] rev_bytes(input logic [127:0] v, input int nbytes);
    logic [127:0] r = '0;
    for (int i = 0; i < nbytes; i++) r = (r << 8) | ((v >> (8 * i)) & 128'hff);
    return r;
  endfunction

  task automatic model_reset();
    m_route = 1'b0; m_swap = 1'b0; m_started = 1'b0;
    m_phase = 0; m_run = 0; m_wr = 0; m_rd = 0;
    m_sync[0] = 1'b1; m_sync[1] = 1'b1;
  endtask

  task automatic check_all();
    bit on, dr, aw_en, ar_en;
    logic [AW-1:0] awa, ara;
    logic [DW-1:0] wd, rd;
    logic [127:0] e_spi;
    on = !m_route; dr = (m_phase == 2);
    aw_en = on && !dr && (m_wr < MAXO);
    ar_en = on && !dr && (m_rd < MAXO);
    awa = m_swap ? AW'(rev_bytes(128'(br_aw_addr_i), AW / 8)) : br_aw_addr_i;
    ara = m_swap ? AW'(rev_bytes(128'(br_ar_addr_i), AW / 8)) : br_ar_addr_i;
    wd  = m_swap ? DW'(rev_bytes(128'(br_w_data_i), DW / 8)) : br_w_data_i;
    rd  = m_swap ? DW'(rev_bytes(128'(zynq_r_data_i), DW / 8)) : zynq_r_data_i;
    if (dr)      e_spi = 128'({4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 2'b00, 4'h0});
    else if (on) e_spi = 128'({br_spi_sdo_i, pulp_spi_clk_i, pulp_spi_csn_i, pulp_spi_sdo_i,
                               1'b0, 1'b1, 2'b00, 4'h0});
    else         e_spi = 128'({pad_spi_sdi_i, 1'b0, 1'b1, 4'h0,
                               pulp_spi_clk_i, pulp_spi_csn_i, pulp_spi_mode_i, pulp_spi_sdo_i});
    chk("ctl", 128'({route_o, busy_o}), 128'({m_route, m_phase != 0}));
    chk("spi", 128'({pulp_spi_sdi_o, br_spi_clk_o, br_spi_csn_o, br_spi_sdi_o,
                     pad_spi_clk_o, pad_spi_csn_o, pad_spi_mode_o, pad_spi_sdo_o}), e_spi);
    chk("aw", 128'({zynq_aw_valid_o, zynq_aw_addr_o, br_aw_ready_o}),
        128'({br_aw_valid_i && aw_en, awa, zynq_aw_ready_i && aw_en}));
    chk("ar", 128'({zynq_ar_valid_o, zynq_ar_addr_o, br_ar_ready_o}),
        128'({br_ar_valid_i && ar_en, ara, zynq_ar_ready_i && ar_en}));
    chk("w", 128'({zynq_w_valid_o, zynq_w_last_o, zynq_w_data_o, br_w_ready_o}),
        128'({br_w_valid_i && on, br_w_last_i, wd, zynq_w_ready_i && on}));
    chk("r", 128'({br_r_valid_o, br_r_last_o, br_r_data_o, zynq_r_ready_o}),
        128'({zynq_r_valid_i && on, zynq_r_last_i, rd, br_r_ready_i && on}));
    chk("b", 128'({br_b_valid_o, zynq_b_ready_o}), 128'({zynq_b_valid_i && on, br_b_ready_i && on}));
  endtask

  task automatic model_update();
    bit on, aw_en, ar_en, aw_hs, ar_hs, b_hs, r_hs, csn_s, req;
    if (!zynq_rst_n) begin
      model_reset();
      return;
    end
    on = !m_route;
    aw_en = on && m_phase != 2 && m_wr < MAXO;
    ar_en = on && m_phase != 2 && m_rd < MAXO;
    aw_hs = br_aw_valid_i && zynq_aw_ready_i && aw_en;
    ar_hs = br_ar_valid_i && zynq_ar_ready_i && ar_en;
    b_hs  = on && zynq_b_valid_i && br_b_ready_i;
    r_hs  = on && zynq_r_valid_i && br_r_ready_i && zynq_r_last_i;
    csn_s = m_sync[1];
    req   = route_req_i;
    if (!m_started) begin
      m_swap = swap_en_i;
      m_started = 1'b1;
    end
    case (m_phase)
      0: if (req != m_route) begin m_phase = 1; m_run = 0; end
      1: begin
        if (req == m_route) m_phase = 0;
        else if (csn_s) begin
          m_run++;
          if (m_run == IDLE) m_phase = 2;
        end else m_run = 0;
      end
      default: begin
        if (req == m_route) m_phase = 0;
        else if (m_wr == 0 && m_rd == 0) begin
          m_route = req; m_swap = swap_en_i; m_phase = 0;
        end
      end
    endcase
    m_wr += int'(aw_hs) - int'(b_hs);
    m_rd += int'(ar_hs) - int'(r_hs);
    m_sync[1] = m_sync[0];
    m_sync[0] = pulp_spi_csn_i;
  endtask

  // inputs are changed right after a negedge; outputs checked 1 time unit later
  task automatic step();
    #1 check_all();
    @(posedge zynq_clk);
    model_update();
    @(negedge zynq_clk);
  endtask

  task automatic wait_route(input bit r, input string tag);
    int n = 0;
    while (route_o !== r && n < 40) begin step(); n++; end
    chk(tag, 128'(route_o), 128'(r));
  endtask

  initial begin
    route_req_i = 0; swap_en_i = 1; pulp_spi_clk_i = 0; pulp_spi_csn_i = 1; pulp_spi_mode_i = 0;
    pulp_spi_sdo_i = 0; br_spi_sdo_i = 0; pad_spi_sdi_i = 0;
    br_aw_valid_i = 0; br_aw_addr_i = 0; zynq_aw_ready_i = 0;
    br_ar_valid_i = 0; br_ar_addr_i = 0; zynq_ar_ready_i = 0;
    br_w_valid_i = 0; br_w_last_i = 0; br_w_data_i = 0; zynq_w_ready_i = 0;
    zynq_r_valid_i = 0; zynq_r_last_i = 0; zynq_r_data_i = 0; br_r_ready_i = 0;
    zynq_b_valid_i = 0; br_b_ready_i = 0;
    model_reset();
    repeat (3) step();
    chk("rst_route", 128'(route_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_pad_csn", 128'(pad_spi_csn_o), 128'(1));
    zynq_rst_n = 1;
    step();

    // byte swap on the Zynq route
    br_aw_valid_i = 1; br_aw_addr_i = 32'h1A10_2000; br_w_data_i = 32'hDEAD_BEEF;
    #1;
    chk("swap_aw", 128'(zynq_aw_addr_o), 128'h0020_101A);
    chk("swap_w", 128'(zynq_w_data_o), 128'hEFBE_ADDE);
    step();
    br_aw_valid_i = 0;

    // CSN activity holds the switch in WAIT_IDLE
    route_req_i = 1;
    for (int c = 0; c < 60; c++) begin
      pulp_spi_csn_i = (c % 10 != 9);
      step();
    end
    chk("csn_busy_route", 128'(route_o), 128'(0));
    chk("csn_busy_flag", 128'(busy_o), 128'(1));
    pulp_spi_csn_i = 1;
    wait_route(1, "csn_idle_switch");
    pulp_spi_csn_i = 0;
    #1;
    chk("fmc_pad_csn", 128'(pad_spi_csn_o), 128'(0));
    chk("fmc_br_csn", 128'(br_spi_csn_o), 128'(1));
    pulp_spi_csn_i = 1;
    route_req_i = 0;
    wait_route(0, "back_to_zynq1");

    // three writes outstanding delay the switch until the third B
    br_aw_valid_i = 1; zynq_aw_ready_i = 1;
    repeat (3) step();
    br_aw_valid_i = 0;
    route_req_i = 1;
    repeat (20) step();
    chk("drain_busy", 128'(busy_o), 128'(1));
    br_aw_valid_i = 1;
    #1;
    chk("drain_aw_blk", 128'({zynq_aw_valid_o, br_aw_ready_o}), 128'(0));
    br_aw_valid_i = 0;
    zynq_b_valid_i = 1; br_b_ready_i = 1;
    repeat (3) step();
    zynq_b_valid_i = 0; br_b_ready_i = 0;
    chk("b3_route_hold", 128'(route_o), 128'(0));
    step();
    chk("b3_route_sw", 128'(route_o), 128'(1));
    route_req_i = 0;
    wait_route(0, "back_to_zynq2");

    // simultaneous AW and B at count 2, then fill to the limit
    br_aw_valid_i = 1; zynq_aw_ready_i = 1;
    repeat (2) step();
    zynq_b_valid_i = 1; br_b_ready_i = 1;
    step();
    zynq_b_valid_i = 0; br_b_ready_i = 0;
    begin
      int n = 0;
      #1;
      while (br_aw_ready_o && n < 20) begin step(); n++; end
      chk("aw_fill_to_max", 128'(n), 128'(6));
    end
    chk("aw_full_blk", 128'({zynq_aw_valid_o, br_aw_ready_o}), 128'(0));
    br_aw_valid_i = 0;
    zynq_b_valid_i = 1; br_b_ready_i = 1;
    repeat (8) step();
    zynq_b_valid_i = 0; br_b_ready_i = 0;

    // revert within WAIT_IDLE
    route_req_i = 1;
    repeat (5) step();
    chk("rv_wait_busy1", 128'(busy_o), 128'(1));
    route_req_i = 0;
    step();
    chk("rv_wait_busy0", 128'(busy_o), 128'(0));
    chk("rv_wait_route", 128'(route_o), 128'(0));

    // revert within DRAIN (one write outstanding keeps it there)
    br_aw_valid_i = 1;
    step();
    br_aw_valid_i = 0;
    route_req_i = 1;
    repeat (20) step();
    chk("rv_drain_busy", 128'(busy_o), 128'(1));
    br_aw_valid_i = 1;
    #1;
    chk("rv_drain_blk", 128'(br_aw_ready_o), 128'(0));
    route_req_i = 0;
    step();
    chk("rv_drain_unblk", 128'(br_aw_ready_o), 128'(1));
    chk("rv_drain_route", 128'(route_o), 128'(0));
    br_aw_valid_i = 0;
    zynq_b_valid_i = 1; br_b_ready_i = 1;
    step();
    zynq_b_valid_i = 0; br_b_ready_i = 0;

    // reset in the middle of DRAIN
    br_aw_valid_i = 1;
    repeat (2) step();
    br_aw_valid_i = 0; br_ar_valid_i = 1; zynq_ar_ready_i = 1;
    step();
    br_ar_valid_i = 0;
    route_req_i = 1;
    repeat (20) step();
    chk("rst_mid_busy1", 128'(busy_o), 128'(1));
    zynq_rst_n = 0;
    model_reset();
    #1;
    chk("rst_mid_route", 128'(route_o), 128'(0));
    chk("rst_mid_busy0", 128'(busy_o), 128'(0));
    chk("rst_mid_pad_csn", 128'(pad_spi_csn_o), 128'(1));
    route_req_i = 0;
    step();
    zynq_rst_n = 1;
    step();
    route_req_i = 1;
    wait_route(1, "post_rst_cnt_zero");
    route_req_i = 0;
    wait_route(0, "back_to_zynq3");

    // random traffic with occasional route requests and CSN activity
    for (int c = 0; c < 3000 && (n_chk - n_pass) < 100; c++) begin
      if ($urandom_range(59) == 0) route_req_i = ~route_req_i;
      if ($urandom_range(pulp_spi_csn_i ? 24 : 5) == 0) pulp_spi_csn_i = ~pulp_spi_csn_i;
      if ($urandom_range(199) == 0) swap_en_i = ~swap_en_i;
      pulp_spi_clk_i = 1'($urandom_range(1));
      pulp_spi_mode_i = 2'($urandom());
      pulp_spi_sdo_i = NL'($urandom()); br_spi_sdo_i = NL'($urandom()); pad_spi_sdi_i = NL'($urandom());
      br_aw_valid_i = 1'($urandom_range(1)); br_aw_addr_i = AW'($urandom()); zynq_aw_ready_i = 1'($urandom_range(1));
      br_ar_valid_i = 1'($urandom_range(1)); br_ar_addr_i = AW'($urandom()); zynq_ar_ready_i = 1'($urandom_range(1));
      br_w_valid_i = 1'($urandom_range(1)); br_w_last_i = 1'($urandom_range(1));
      br_w_data_i = DW'($urandom()); zynq_w_ready_i = 1'($urandom_range(1));
      zynq_r_valid_i = 1'($urandom_range(1)); zynq_r_last_i = (m_rd > 0) && ($urandom_range(1) == 0);
      zynq_r_data_i = DW'($urandom()); br_r_ready_i = 1'($urandom_range(1));
      zynq_b_valid_i = (m_wr > 0) && ($urandom_range(2) == 0); br_b_ready_i = 1'($urandom_range(1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
